// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_rx_oversampled                                           |
// | Purpose  : Oversampling UART receiver with runtime baud divisor,         |
// |            DATA_BITS data bits (LSB first), optional even/odd parity,    |
// |            one or two stop bits, and a one-entry valid/ready output      |
// |            buffer with sticky overrun and per-frame error flags.         |
// | Ports    : src_clk, rst (sync, active-high)                              |
// |            DataIn      - async serial line, idle high                    |
// |            baud_div    - src_clk cycles per oversample tick minus 1      |
// |            parity_en / parity_odd / two_stop - frame format              |
// |            data_ready  - consumer accepts data_out                       |
// |            overrun_clr - clears the sticky overrun flag                  |
// |            data_out / data_valid / parity_err / frame_err - frame buffer |
// |            overrun     - sticky, a frame was dropped on a full buffer    |
// |            busy        - receiver is not idle                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 src_clk,
    input  logic                 rst,
    input  logic                 DataIn,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    input  logic                 data_ready,
    input  logic                 overrun_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_OS_W  = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(DATA_BITS);

    // Tick index (counted from 0) on which a bit is sampled.
    localparam logic [c_OS_W-1:0]  c_HALF_LAST = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_FULL_LAST = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BITS_LAST = c_BIT_W'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP1  = 3'd4;
    localparam logic [2:0] c_ST_STOP2  = 3'd5;
    localparam logic [2:0] c_ST_COMMIT = 3'd6;
    localparam logic [2:0] c_ST_BREAK  = 3'd7;

    // Registers
    logic                 r_sync1, r_sync2;
    logic [2:0]           r_state;
    logic [DIV_WIDTH-1:0] r_div_cnt;
    logic [c_OS_W-1:0]    r_os_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_en, r_par_odd, r_two_stop;
    logic                 r_perr_acc, r_ferr_acc;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid, r_parity_err, r_frame_err, r_overrun;

    // Next-state values
    logic [2:0]           w_state_nxt;
    logic [DIV_WIDTH-1:0] w_div_cnt_nxt;
    logic [c_OS_W-1:0]    w_os_cnt_nxt;
    logic [c_BIT_W-1:0]   w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 w_par_en_nxt, w_par_odd_nxt, w_two_stop_nxt;
    logic                 w_perr_acc_nxt, w_ferr_acc_nxt;
    logic [DATA_BITS-1:0] w_data_out_nxt;
    logic                 w_data_valid_nxt, w_parity_err_nxt, w_frame_err_nxt, w_overrun_nxt;

    // Timing and FSM decode
    logic                 w_rx_s;
    logic                 w_tick;
    logic [c_OS_W-1:0]    w_os_last;
    logic                 w_sample;
    logic                 w_counting, w_start_det, w_commit;
    logic                 w_shift_en, w_par_smp, w_stop1_smp, w_stop2_smp, w_busy;
    logic                 w_load, w_drop;

    assign w_rx_s    = r_sync2;
    assign w_tick    = (r_div_cnt == baud_div);
    // START samples at mid-bit; after that every sample is one full bit apart,
    // so the tick counter restarts from 0 at every sample point.
    assign w_os_last = (r_state == c_ST_START) ? c_HALF_LAST : c_FULL_LAST;
    assign w_sample  = w_tick && (r_os_cnt == w_os_last);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (!w_rx_s) w_state_nxt = c_ST_START;
            c_ST_START:  if (w_sample) w_state_nxt = w_rx_s ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:   if (w_sample && (r_bit_cnt == c_BITS_LAST))
                             w_state_nxt = r_par_en ? c_ST_PARITY : c_ST_STOP1;
            c_ST_PARITY: if (w_sample) w_state_nxt = c_ST_STOP1;
            c_ST_STOP1:  if (w_sample) w_state_nxt = r_two_stop ? c_ST_STOP2 : c_ST_COMMIT;
            c_ST_STOP2:  if (w_sample) w_state_nxt = c_ST_COMMIT;
            // A low line after a framing error is a break: park until it rises
            // so a held-low line cannot be re-read as a stream of frames.
            c_ST_COMMIT: w_state_nxt = (r_ferr_acc && !w_rx_s) ? c_ST_BREAK : c_ST_IDLE;
            c_ST_BREAK:  if (w_rx_s) w_state_nxt = c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // ---------------- FSM: output decode ----------------
    always_comb begin
        w_counting  = 1'b0;
        w_start_det = 1'b0;
        w_commit    = 1'b0;
        w_shift_en  = 1'b0;
        w_par_smp   = 1'b0;
        w_stop1_smp = 1'b0;
        w_stop2_smp = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                w_busy      = 1'b0;
                w_start_det = ~w_rx_s;
            end
            c_ST_START:  w_counting = 1'b1;
            c_ST_DATA: begin
                w_counting = 1'b1;
                w_shift_en = w_sample;
            end
            c_ST_PARITY: begin
                w_counting = 1'b1;
                w_par_smp  = w_sample;
            end
            c_ST_STOP1: begin
                w_counting  = 1'b1;
                w_stop1_smp = w_sample;
            end
            c_ST_STOP2: begin
                w_counting  = 1'b1;
                w_stop2_smp = w_sample;
            end
            c_ST_COMMIT: w_commit = 1'b1;
            default: ;
        endcase
    end

    assign busy = w_busy;

    // ---------------- Datapath next-state ----------------
    always_comb begin
        // Baud/oversample counters run only while a frame is being timed;
        // holding them at zero otherwise aligns the first tick to start detect.
        w_div_cnt_nxt = '0;
        w_os_cnt_nxt  = '0;
        if (w_counting) begin
            w_div_cnt_nxt = w_tick ? '0 : r_div_cnt + DIV_WIDTH'(1);
            if (w_sample) begin
                w_os_cnt_nxt = '0;
            end else if (w_tick) begin
                w_os_cnt_nxt = r_os_cnt + c_OS_W'(1);
            end else begin
                w_os_cnt_nxt = r_os_cnt;
            end
        end

        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_par_en_nxt   = r_par_en;
        w_par_odd_nxt  = r_par_odd;
        w_two_stop_nxt = r_two_stop;
        w_perr_acc_nxt = r_perr_acc;
        w_ferr_acc_nxt = r_ferr_acc;

        if (w_start_det) begin
            w_bit_cnt_nxt  = '0;
            w_par_en_nxt   = parity_en;
            w_par_odd_nxt  = parity_odd;
            w_two_stop_nxt = two_stop;
            w_perr_acc_nxt = 1'b0;
            w_ferr_acc_nxt = 1'b0;
        end
        if (w_shift_en) begin
            w_shift_nxt   = {w_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + c_BIT_W'(1);
        end
        if (w_par_smp) begin
            w_perr_acc_nxt = ((^r_shift) ^ w_rx_s) != r_par_odd;
        end
        if (w_stop1_smp) begin
            w_ferr_acc_nxt = ~w_rx_s;
        end
        if (w_stop2_smp) begin
            w_ferr_acc_nxt = r_ferr_acc | ~w_rx_s;
        end

        // One-entry output buffer: a commit may refill it in the same cycle the
        // consumer drains it; otherwise a commit into a full buffer is dropped.
        w_load = w_commit && (!r_data_valid || data_ready);
        w_drop = w_commit && r_data_valid && !data_ready;

        w_data_out_nxt   = r_data_out;
        w_parity_err_nxt = r_parity_err;
        w_frame_err_nxt  = r_frame_err;
        w_data_valid_nxt = r_data_valid;
        if (w_load) begin
            w_data_out_nxt   = r_shift;
            w_parity_err_nxt = r_perr_acc;
            w_frame_err_nxt  = r_ferr_acc;
            w_data_valid_nxt = 1'b1;
        end else if (r_data_valid && data_ready) begin
            w_data_valid_nxt = 1'b0;
        end

        // Set has priority over clear.
        if (w_drop) begin
            w_overrun_nxt = 1'b1;
        end else if (overrun_clr) begin
            w_overrun_nxt = 1'b0;
        end else begin
            w_overrun_nxt = r_overrun;
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_div_cnt    <= '0;
            r_os_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_en     <= 1'b0;
            r_par_odd    <= 1'b0;
            r_two_stop   <= 1'b0;
            r_perr_acc   <= 1'b0;
            r_ferr_acc   <= 1'b0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_sync1      <= DataIn;
            r_sync2      <= r_sync1;
            r_div_cnt    <= w_div_cnt_nxt;
            r_os_cnt     <= w_os_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_par_en     <= w_par_en_nxt;
            r_par_odd    <= w_par_odd_nxt;
            r_two_stop   <= w_two_stop_nxt;
            r_perr_acc   <= w_perr_acc_nxt;
            r_ferr_acc   <= w_ferr_acc_nxt;
            r_data_out   <= w_data_out_nxt;
            r_data_valid <= w_data_valid_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign parity_err = r_parity_err;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_rx_oversampled                                        |
// | Purpose  : Directed-vector bench for uart_rx_oversampled. Expected       |
// |            frames are queued as they are sent; a monitor pops and        |
// |            compares whenever the DUT presents a new frame.               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_uart_rx_oversampled;

    logic        src_clk;
    logic        rst;
    logic        DataIn;
    logic [15:0] baud_div;
    logic        parity_en, parity_odd, two_stop;
    logic        data_ready, overrun_clr;
    logic [7:0]  data_out;
    logic        data_valid, parity_err, frame_err, overrun, busy;

    uart_rx_oversampled #(
        .DATA_BITS (8),
        .OVERSAMPLE(16),
        .DIV_WIDTH (16)
    ) u_dut (
        .src_clk    (src_clk),
        .rst        (rst),
        .DataIn     (DataIn),
        .baud_div   (baud_div),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .data_ready (data_ready),
        .overrun_clr(overrun_clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial src_clk = 1'b0;
    always #10 src_clk = ~src_clk;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // ---------------- Scoreboard monitor ----------------
    logic mon_v_prev = 1'b0;
    logic mon_r_prev = 1'b0;

    always @(negedge src_clk) begin
        exp_t e;
        if (!rst && data_valid && (!mon_v_prev || mon_r_prev)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame actual data=%0h pe=%0b fe=%0b required none",
                         data_out, parity_err, frame_err);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.d || parity_err !== e.pe || frame_err !== e.fe) begin
                    errors++;
                    $display("FAIL frame actual data=%0h pe=%0b fe=%0b required data=%0h pe=%0b fe=%0b",
                             data_out, parity_err, frame_err, e.d, e.pe, e.fe);
                end
            end
        end
        mon_v_prev = data_valid;
        mon_r_prev = data_ready;
    end

    // ---------------- Helpers ----------------
    task automatic cyc();
        @(posedge src_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 16 * (int'(baud_div) + 1);
        DataIn = b;
        repeat (n) cyc();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic pbit,
                              input logic stop_v, input logic two);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (par) send_bit(pbit);
        send_bit(stop_v);
        if (two) send_bit(1'b1);
    endtask

    task automatic pulse_ready();
        data_ready = 1'b1;
        cyc();
        data_ready = 1'b0;
    endtask

    // ---------------- Stimulus ----------------
    initial begin
        int waited;
        rst = 1'b1; DataIn = 1'b1; baud_div = 16'd324;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        data_ready = 1'b0; overrun_clr = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        chk("rst_data_out",   32'(data_out),   32'h0);
        chk("rst_data_valid", 32'(data_valid), 32'h0);
        chk("rst_parity_err", 32'(parity_err), 32'h0);
        chk("rst_frame_err",  32'(frame_err),  32'h0);
        chk("rst_overrun",    32'(overrun),    32'h0);
        chk("rst_busy",       32'(busy),       32'h0);

        // 8N1 0x52 at 9600 baud, consumer not ready.
        exp_q.push_back('{d: 8'h52, pe: 1'b0, fe: 1'b0});
        send_frame(8'h52, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t1_valid", 32'(data_valid), 32'h1);
        chk("t1_data",  32'(data_out),   32'h52);
        repeat (100) cyc();
        chk("t1_hold_valid", 32'(data_valid), 32'h1);
        chk("t1_hold_data",  32'(data_out),   32'h52);
        pulse_ready();
        chk("t1_valid_drop", 32'(data_valid), 32'h0);

        // Low glitch shorter than half a bit.
        DataIn = 1'b0;
        repeat (10) cyc();
        chk("glitch_busy", 32'(busy), 32'h1);
        repeat (990) cyc();
        DataIn = 1'b1;
        waited = 1000;
        while (busy && waited < 2700) begin
            cyc();
            waited++;
        end
        chk("glitch_busy_release", 32'(busy), 32'h0);
        chk("glitch_no_valid", 32'(data_valid), 32'h0);

        // Faster baud for the remaining tests: 64 cycles per bit.
        baud_div = 16'd3;
        repeat (20) cyc();

        // 8E1 / 8O1 parity, consumer always ready.
        data_ready = 1'b1;
        parity_en  = 1'b1;
        exp_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
        send_frame(8'h5A, 1'b1, 1'b0, 1'b1, 1'b0);
        exp_q.push_back('{d: 8'h5A, pe: 1'b1, fe: 1'b0});
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        parity_odd = 1'b1;
        exp_q.push_back('{d: 8'h5A, pe: 1'b0, fe: 1'b0});
        send_frame(8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
        parity_en = 1'b0; parity_odd = 1'b0;

        // 8N2 frame.
        two_stop = 1'b1;
        exp_q.push_back('{d: 8'hC3, pe: 1'b0, fe: 1'b0});
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
        two_stop = 1'b0;
        repeat (64) cyc();

        // Stop bit low, then line held low for three bit times.
        data_ready = 1'b0;
        exp_q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b1});
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3 * 64) cyc();
        chk("brk_busy_low", 32'(busy),       32'h1);
        chk("brk_valid",    32'(data_valid), 32'h1);
        chk("brk_ferr",     32'(frame_err),  32'h1);
        DataIn = 1'b1;
        repeat (6) cyc();
        chk("brk_busy_release", 32'(busy),    32'h0);
        repeat (128) cyc();
        chk("brk_no_overrun",   32'(overrun), 32'h0);
        pulse_ready();
        chk("brk_valid_drop", 32'(data_valid), 32'h0);

        // Back-to-back frames into a full buffer.
        exp_q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (10) cyc();
        chk("ovr_data", 32'(data_out), 32'h11);
        chk("ovr_flag", 32'(overrun),  32'h1);
        pulse_ready();
        chk("ovr_valid_drop", 32'(data_valid), 32'h0);
        chk("ovr_sticky",     32'(overrun),    32'h1);
        overrun_clr = 1'b1;
        cyc();
        overrun_clr = 1'b0;
        chk("ovr_clear", 32'(overrun), 32'h0);

        // Reset during data bit 4 of 0x52, then 0x33.
        data_ready = 1'b1;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h52 >> i));
        DataIn = 1'b1;
        repeat (32) cyc();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (128) cyc();
        chk("rst_mid_busy",  32'(busy),       32'h0);
        chk("rst_mid_valid", 32'(data_valid), 32'h0);
        exp_q.push_back('{d: 8'h33, pe: 1'b0, fe: 1'b0});
        send_frame(8'h33, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (128) cyc();

        chk("pending_frames", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
